// File: rtl/car_cmd_pkg.sv
// Shared steering-command definitions: ASCII command bytes, mux select
// codes, UART receiver state encoding and the command decode helper.
package car_cmd_pkg;

    localparam logic [7:0] CMD_FWD   = 8'h46;  // 'F'
    localparam logic [7:0] CMD_LEFT  = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_RIGHT = 8'h52;  // 'R'
    localparam logic [7:0] CMD_STOP  = 8'h53;  // 'S'

    localparam logic [1:0] SEL_FWD   = 2'b00;
    localparam logic [1:0] SEL_LEFT  = 2'b01;
    localparam logic [1:0] SEL_RIGHT = 2'b10;
    localparam logic [1:0] SEL_STOP  = 2'b11;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_DONE
    } rx_state_t;

    typedef struct packed {
        logic       known;
        logic [1:0] sel;
    } cmd_dec_t;

    // Map a received byte to a select code; unknown bytes leave known=0.
    function automatic cmd_dec_t decode_cmd(input logic [7:0] b);
        cmd_dec_t d;
        d.known = 1'b1;
        d.sel   = SEL_STOP;
        case (b)
            CMD_FWD:   d.sel = SEL_FWD;
            CMD_LEFT:  d.sel = SEL_LEFT;
            CMD_RIGHT: d.sel = SEL_RIGHT;
            CMD_STOP:  d.sel = SEL_STOP;
            default:   d.known = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/uart_sel_decoder_rx_core.sv
// 8N1 UART receiver: 2-flop input synchroniser, baud/bit counters and a
// five-state receive FSM. Presents the byte with a one-cycle rx_done and
// flags a low stop bit with a one-cycle frame_err.
module uart_rx_core
    import car_cmd_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);

    rx_state_t         state;
    rx_state_t         state_nxt;
    logic              rx_m;
    logic              rx_s;
    logic              armed;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
    logic              baud_tick;
    logic              half_tick;

    assign baud_tick = (baud_cnt == BAUD_LAST);
    assign half_tick = (baud_cnt == HALF_LAST);
    assign rx_data   = shreg;

    // Two-flop synchroniser, preset to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Receive FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RX_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; a start is accepted only once the line has been seen high.
    always_comb begin
        state_nxt = state;
        case (state)
            RX_IDLE:  if (!rx_s && armed)          state_nxt = RX_START;
            RX_START: if (half_tick)               state_nxt = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (baud_tick && bit_cnt == 3'd7) state_nxt = RX_STOP;
            RX_STOP:  if (baud_tick)               state_nxt = rx_s ? RX_DONE : RX_IDLE;
            RX_DONE:                               state_nxt = RX_IDLE;
            default:                               state_nxt = RX_IDLE;
        endcase
    end

    // Outputs: byte-ready during DONE, framing error on a low stop sample.
    always_comb begin
        rx_done   = (state == RX_DONE);
        frame_err = (state == RX_STOP) && baud_tick && !rx_s;
    end

    // Baud counter, bit counter and LSB-first shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                RX_START: baud_cnt <= half_tick ? '0 : baud_cnt + BAUD_W'(1);
                RX_DATA: begin
                    if (baud_tick) begin
                        baud_cnt <= '0;
                        bit_cnt  <= bit_cnt + 3'd1;
                        shreg    <= {rx_s, shreg[7:1]};
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                RX_STOP:  baud_cnt <= baud_tick ? '0 : baud_cnt + BAUD_W'(1);
                default: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end
            endcase
        end
    end

    // Start-detect arming: dropped after a framing error until the line is high again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         armed <= 1'b1;
        else if (frame_err) armed <= 1'b0;
        else if (rx_s)      armed <= 1'b1;
    end

endmodule

// File: rtl/uart_sel_decoder.sv
// UART steering-command decoder: turns received ASCII commands into the
// 2-bit mux select, holds the last valid selection and forces STOP when
// no valid command arrives within the watchdog window.
module uart_sel_decoder
    import car_cmd_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT   = 5208,
    parameter int unsigned TIMEOUT_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [1:0] sel,
    output logic       sel_valid,
    output logic       cmd_strobe,
    output logic       bad_cmd,
    output logic       frame_err
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [7:0]      rx_data;
    logic            rx_done;
    logic            rx_frame_err;
    cmd_dec_t        dec;
    logic            cmd_hit;
    logic            cmd_miss;
    logic [WD_W-1:0] wd_cnt;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .frame_err(rx_frame_err)
    );

    // Classify each completed byte as a known command or a bad one.
    always_comb begin
        dec      = decode_cmd(rx_data);
        cmd_hit  = rx_done && dec.known;
        cmd_miss = rx_done && !dec.known;
    end

    // Selection register and watchdog; a command in the timeout cycle takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel       <= SEL_STOP;
            sel_valid <= 1'b0;
            wd_cnt    <= '0;
        end else if (cmd_hit) begin
            sel       <= dec.sel;
            sel_valid <= 1'b1;
            wd_cnt    <= '0;
        end else if (sel_valid) begin
            if (wd_cnt == WD_LAST) begin
                sel       <= SEL_STOP;
                sel_valid <= 1'b0;
                wd_cnt    <= '0;
            end else begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
        end
    end

    // One-cycle status pulses, aligned with the selection update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_strobe <= 1'b0;
            bad_cmd    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            cmd_strobe <= cmd_hit;
            bad_cmd    <= cmd_miss;
            frame_err  <= rx_frame_err;
        end
    end

endmodule

// File: doc/uart_sel_decoder.md
Name: uart_sel_decoder

Overview:
- Upstream stage of the 4:1 two-bit path-select mux.
- Receives 8N1 UART command bytes from the host or Bluetooth link and decodes ASCII steering commands into the mux `sel` code.
- Holds the last valid selection.
- A watchdog forces a safe STOP code if the link goes silent.

Parameters:
- CLKS_PER_BIT, default 5208: system clocks per UART bit (50 MHz / 9600 baud); must be at least 8.
- TIMEOUT_CYCLES, default 25_000_000: clocks with no valid command before a forced STOP (0.5 s).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  UART serial line; idles high; asynchronous to clk.
- sel  output  2  mux select code driven to the mux `sel` input.
- sel_valid  output  1  high while `sel` comes from a live command; low after reset or watchdog timeout.
- cmd_strobe  output  1  one-cycle pulse when a valid command updates `sel`.
- bad_cmd  output  1  one-cycle pulse when a well-framed byte is not a known command.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.

Behaviour:
- Reset values (async on rst_n low): `sel`=2'b11, `sel_valid`=0, all pulses 0, FSM in IDLE, bit counter 0, watchdog counter 0, synchroniser flops preset to 1.
- Input sync: `rx` passes through a 2-flop synchroniser. All decisions use the synchronised signal `rx_s`.
- Receive FSM states: IDLE, START, DATA, STOP, DONE.
  - IDLE -> START on `rx_s`=0. The baud counter clears.
  - START: at CLKS_PER_BIT/2, if `rx_s`=0 go to DATA (counter clears). If `rx_s`=1, treat as a glitch: return to IDLE with no pulse.
  - DATA: sample `rx_s` every CLKS_PER_BIT, LSB first, into a shift register. After 8 samples go to STOP.
  - STOP: sample at CLKS_PER_BIT.
    - If `rx_s`=1, go to DONE.
    - If `rx_s`=0, pulse `frame_err`, discard the byte, and return to IDLE. The next start is not detected until `rx_s` returns high.
  - DONE: lasts one cycle. It decodes the byte and returns to IDLE.
- Decode table (exact ASCII, uppercase only):
  - 'F' 0x46 -> 2'b00
  - 'L' 0x4C -> 2'b01
  - 'R' 0x52 -> 2'b10
  - 'S' 0x53 -> 2'b11
- Known byte:
  - `sel` updates on the clock after DONE.
  - `sel_valid`=1, `cmd_strobe` pulses in the same cycle, and the watchdog clears.
- Unknown byte: `bad_cmd` pulses; `sel`, `sel_valid` and the watchdog are unchanged.
- Latency: `sel` changes 1 clock after the stop-bit sample, about 9.5 bit times plus 3 clocks after the start edge.
- Watchdog:
  - The counter increments every clock while `sel_valid`=1.
  - When it reaches TIMEOUT_CYCLES-1: `sel` becomes 2'b11, `sel_valid` goes to 0, and the counter holds at 0.
  - If a valid command arrives in the same cycle as the timeout, the command wins.
- Repeating the same command still pulses `cmd_strobe` and clears the watchdog.
- Back-to-back frames with zero idle time between stop bit and next start bit must be received without loss.
- Asserting rst_n low mid-frame aborts the frame. After release, the FSM waits in IDLE for a fresh falling edge; a partial frame still in flight may cause `frame_err` or `bad_cmd` but must never produce `cmd_strobe`.
- Counters:
  - Baud counter is $clog2(CLKS_PER_BIT) bits.
  - Bit counter is 3 bits.
  - Watchdog counter is $clog2(TIMEOUT_CYCLES) bits.
  - All compares are unsigned; no wrap occurs in normal operation.

Decomposition:
- Shared package `car_cmd_pkg`:
  - Localparams CMD_FWD=8'h46, CMD_LEFT=8'h4C, CMD_RIGHT=8'h52, CMD_STOP=8'h53.
  - Localparams SEL_FWD=2'b00, SEL_LEFT=2'b01, SEL_RIGHT=2'b10, SEL_STOP=2'b11.
  - The FSM state encoding.
- One natural sub-module: `uart_rx_core`.
  - Contains the synchroniser, baud/bit counters and FSM.
  - Outputs `rx_data[7:0]`, `rx_done` (1-cycle) and `frame_err`.
  - The top level holds the decode table and the watchdog.

Test Plan (sim with CLKS_PER_BIT=16, TIMEOUT_CYCLES=2000):
1. Reset, idle `rx`=1 for 500 clocks -> `sel`=2'b11, `sel_valid`=0, no pulses.
2. Send 0x46, then 0x4C, then 0x52 back-to-back with zero idle -> `sel` goes 00, 01, 10 in order; exactly 3 `cmd_strobe` pulses; `sel_valid`=1.
3. Send 0x46, then 0x41 ('A') -> `sel` stays 00; one `bad_cmd` pulse; no second `cmd_strobe`.
4. Send 0x52 with the stop bit driven 0 -> `frame_err` pulses once; `sel` unchanged from its prior value.
5. Send 0x4C, then idle 2000 clocks -> `sel`=2'b11 and `sel_valid`=0 at cycle 2000 after the strobe. Then send 0x46 -> `sel`=00, `sel_valid`=1.
6. Drive a 4-clock low glitch on `rx` -> no pulses, FSM back in IDLE. Separately, assert rst_n mid-DATA of 0x46 -> `sel`=11 immediately; no `cmd_strobe` from the aborted frame.
